dmem_mmio: RTL
==============

# dmem_mmio

Parametrised data-memory slave for the RV32 core's load/store port: a byte-enabled RAM window plus a memory-mapped I/O window holding read-only ID words and GPIO_CH switch/LED channel pairs. It adds a valid/ready request handshake, a one-entry buffered response with back-pressure, switch-input synchronisers and an error response for bad accesses. It sits between the core's MEM stage and board I/O.

## Interface
- RAM_WORDS, 1024, RAM depth in 32-bit words (power of two)
- RAM_BASE, 32'h8000_0000, RAM window base (byte address)
- IO_BASE, 32'h0010_0000, I/O window base (byte address)
- ID_WORDS, 3, read-only ID words, 1..4
- ID_VALUES, {32'h18313324, 32'h18700095, 32'h13874751}, packed ID_WORDS×32; word k = bits [32k+31:32k]
- GPIO_CH, 1, switch/LED channel pairs, 1..8

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both high
- req_we  in  4  byte write enables; 4'b0000 = read
- addr_in  in  32  byte address
- data_in  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- data_out  out  32  response data
- rsp_err  out  1  response is an error
- sw_in  in  32×GPIO_CH  asynchronous switch inputs
- led_out  out  32×GPIO_CH  LED registers

## Operation
- Map (offsets from IO_BASE): 0x00+4k = ID word k (k<ID_WORDS); 0x10+8c = switch c; 0x14+8c = LED c (c<GPIO_CH). RAM: RAM_BASE + 4w, w<RAM_WORDS.
- Error (rsp_err=1, data_out=0, no state change): addr_in[1:0]≠0; unmapped address; nonzero req_we to ID or switch.
- Write: bytes with req_we[b]=1 take data_in[8b+7:8b]; other bytes unchanged.
- Every accepted request returns exactly one response; data_out = target word after any write (write-first). Matches a store-then-check flow.
- Switch reads return sw_in after a 2-flop synchroniser per bit.
- led_out = LED registers directly.
- RAM contents not reset; undefined until written.

## Timing
- Reset (rst high at a clk edge): rsp_valid=0, rsp_err=0, data_out=0, all LED registers 0, synchronisers 0, req_ready=1 the cycle after. A request or pending response at reset is discarded.
- req_ready = !rsp_valid || rsp_ready (combinational).
- Accept at edge N → rsp_valid=1 with data at edge N+1 (latency 1). Write takes effect at edge N.
- Response held stable while rsp_valid && !rsp_ready; no new request accepted.
- Simultaneous consume and accept at one edge: response register reloads; back-to-back throughput 1/cycle.
- Switch change visible to a read accepted ≥2 cycles after sw_in settles.
- Write to LED then read of same address next cycle returns new value (no hazard).

## Structure
- Package dmem_mmio_pkg: region enum (RGN_RAM, RGN_ID, RGN_SW, RGN_LED, RGN_NONE), ID/SW/LED offset constants, decode function addr→region+index.
- Sub-module dmem_ram_bank: single-port, byte-enabled, write-first synchronous RAM, parameter RAM_WORDS.
- Top: decode, LED registers, synchronisers, response register/handshake.

## Test plan
- Reset 5 cycles, read IO_BASE+0/4/8 → 32'h13874751, 32'h18700095, 32'h18313324, rsp_err=0, one cycle after acceptance each.
- sw_in=32'hA5A5_0F0F, wait 3 cycles, read IO_BASE+0x10 → 32'hA5A5_0F0F; read IO_BASE+0x14 after reset → 0.
- Write 32'hFEDCBA98 we=4'b1111 to IO_BASE+0x14 → response 32'hFEDCBA98, led_out=32'hFEDCBA98; then we=4'b0010 data 32'h0000_1100 → 32'hFEDC1198.
- 1024 random full-word writes to RAM_BASE+4i, then reads back → all match; partial write we=4'b1000 data 32'h7700_0000 over 32'h1122_3344 → 32'h7722_3344.
- Errors: read RAM_BASE+2, read RAM_BASE+4096, write IO_BASE+0 → rsp_err=1, data_out=0, ID/RAM unchanged on re-read.
- Back-pressure: rsp_ready=0 for 4 cycles with req_valid held → req_ready=0, data_out stable; rsp_ready=1 continuous → 1 response/cycle; rst asserted with rsp_valid=1 → rsp_valid=0 next cycle.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg
//   Shared types and helpers for the data-memory / MMIO slave.
//   - region_e    : which window an address falls in
//   - decode_t    : region plus word/channel index within that region
//   - mmio_decode : byte address -> decode_t (alignment is checked by the caller)
//   - byte_merge  : byte-enable merge of a write into an existing word
package dmem_mmio_pkg;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_ID,
        RGN_SW,
        RGN_LED,
        RGN_NONE
    } region_e;

    typedef struct packed {
        region_e     region;
        logic [31:0] index;
    } decode_t;

    // Offsets within the I/O window
    localparam logic [31:0] ID_OFS      = 32'h0000_0000;
    localparam logic [31:0] SW_OFS      = 32'h0000_0010;
    localparam logic [31:0] LED_OFS     = 32'h0000_0014;
    localparam logic [31:0] GPIO_STRIDE = 32'h0000_0008;

    function automatic decode_t mmio_decode(
        input logic [31:0] addr,
        input logic [31:0] ram_base,
        input logic [31:0] io_base,
        input int unsigned ram_words,
        input int unsigned id_words,
        input int unsigned gpio_ch
    );
        decode_t     d;
        logic [31:0] ram_off;
        logic [31:0] io_off;
        logic [31:0] gpio_rel;
        d.region = RGN_NONE;
        d.index  = '0;
        // Unsigned subtraction wraps addresses below a base to huge offsets,
        // so a single upper-bound compare covers both ends of each window.
        ram_off  = addr - ram_base;
        io_off   = addr - io_base;
        gpio_rel = io_off - SW_OFS;
        if (ram_off < (32'(ram_words) << 2)) begin
            d.region = RGN_RAM;
            d.index  = ram_off >> 2;
        end else if (io_off < ID_OFS + (32'(id_words) << 2)) begin
            d.region = RGN_ID;
            d.index  = (io_off - ID_OFS) >> 2;
        end else if (io_off >= SW_OFS && gpio_rel < 32'(gpio_ch) * GPIO_STRIDE) begin
            // Each channel is an SW/LED pair 8 bytes apart; bit 2 picks the LED half.
            d.region = gpio_rel[2] ? RGN_LED : RGN_SW;
            d.index  = gpio_rel >> 3;
        end
        return d;
    endfunction

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  we
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = we[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// dmem_ram_bank
//   Single-port, byte-enabled, write-first synchronous RAM. Contents are not
//   reset. rdata updates only on cycles with en high, so it holds the last
//   access result for as long as the caller needs it.
// Ports:
//   clk    clock
//   en     access strobe (read, or write when any we bit set)
//   we     byte write enables
//   addr   word address
//   wdata  write data
//   rdata  word at addr after the write (registered)
module dmem_ram_bank #(
    parameter int RAM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic [3:0]                   we,
    input  logic [$clog2(RAM_WORDS)-1:0] addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);

    logic [31:0] mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    rdata[8*b +: 8]     <= wdata[8*b +: 8];
                end else begin
                    rdata[8*b +: 8]     <= mem[addr][8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio
//   Data-memory slave for the core's load/store port: a byte-enabled RAM
//   window plus an I/O window with read-only ID words and switch/LED channel
//   pairs. One-entry response register with valid/ready back-pressure.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we                byte write enables (0 = read)
//   addr_in, data_in      byte address, write data
//   rsp_valid/rsp_ready   response handshake
//   data_out, rsp_err     response word (write-first), error flag
//   sw_in                 asynchronous switch inputs, 32 per channel
//   led_out               LED registers, 32 per channel
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int                       RAM_WORDS = 1024,
    parameter logic [31:0]              RAM_BASE  = 32'h8000_0000,
    parameter logic [31:0]              IO_BASE   = 32'h0010_0000,
    parameter int                       ID_WORDS  = 3,
    parameter logic [32*ID_WORDS-1:0]   ID_VALUES = {32'h18313324, 32'h18700095, 32'h13874751},
    parameter int                       GPIO_CH   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_we,
    input  logic [31:0]            addr_in,
    input  logic [31:0]            data_in,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            data_out,
    output logic                   rsp_err,
    input  logic [32*GPIO_CH-1:0]  sw_in,
    output logic [32*GPIO_CH-1:0]  led_out
);

    localparam int AW = $clog2(RAM_WORDS);

    decode_t               dec;
    logic                  accept;
    logic                  err_c;
    logic                  ram_hit;
    logic                  led_wr;
    logic [31:0]           rd_word;
    logic [31:0]           led_new;
    logic [31:0]           ram_rdata;

    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_data_q;
    logic                  rsp_is_ram_q;
    logic [32*GPIO_CH-1:0] led_q;
    logic [32*GPIO_CH-1:0] sw_meta;
    logic [32*GPIO_CH-1:0] sw_sync;

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        dec = mmio_decode(addr_in, RAM_BASE, IO_BASE, RAM_WORDS, ID_WORDS, GPIO_CH);
    end

    // Target word and error classification for the request on the bus.
    // rd_word stays 0 on every error path so the response carries 0.
    always_comb begin
        err_c   = 1'b0;
        ram_hit = 1'b0;
        led_wr  = 1'b0;
        rd_word = '0;
        led_new = '0;
        if (addr_in[1:0] != 2'b00) begin
            err_c = 1'b1;
        end else begin
            case (dec.region)
                RGN_RAM: ram_hit = 1'b1;
                RGN_ID: begin
                    if (req_we != 4'b0000) begin
                        err_c = 1'b1;
                    end else begin
                        for (int k = 0; k < ID_WORDS; k++) begin
                            if (dec.index == 32'(k)) rd_word = ID_VALUES[32*k +: 32];
                        end
                    end
                end
                RGN_SW: begin
                    if (req_we != 4'b0000) begin
                        err_c = 1'b1;
                    end else begin
                        for (int c = 0; c < GPIO_CH; c++) begin
                            if (dec.index == 32'(c)) rd_word = sw_sync[32*c +: 32];
                        end
                    end
                end
                RGN_LED: begin
                    led_wr = (req_we != 4'b0000);
                    for (int c = 0; c < GPIO_CH; c++) begin
                        if (dec.index == 32'(c)) led_new = byte_merge(led_q[32*c +: 32], data_in, req_we);
                    end
                    rd_word = led_new;
                end
                default: err_c = 1'b1;
            endcase
        end
    end

    // A request presented during reset must not touch RAM.
    dmem_ram_bank #(
        .RAM_WORDS (RAM_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (accept && ram_hit && !rst),
        .we    (req_we),
        .addr  (dec.index[AW-1:0]),
        .wdata (data_in),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            rsp_is_ram_q <= 1'b0;
            led_q        <= '0;
            sw_meta      <= '0;
            sw_sync      <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (accept) begin
                rsp_valid_q  <= 1'b1;
                rsp_err_q    <= err_c;
                rsp_data_q   <= rd_word;
                rsp_is_ram_q <= ram_hit;
                if (led_wr) begin
                    for (int c = 0; c < GPIO_CH; c++) begin
                        if (dec.index == 32'(c)) led_q[32*c +: 32] <= led_new;
                    end
                end
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // RAM data is already registered inside the bank and only changes on a
    // new accepted RAM access, so it is stable while the response is held.
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign data_out  = rsp_is_ram_q ? ram_rdata : rsp_data_q;
    assign led_out   = led_q;

endmodule
